// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling queue: 2 in / 2 out per cycle, two threads, per-thread squash.
// Latency: 1 cycle (enqueue edge, then visible); outputs are combinational from storage.
// Backpressure: stall comes from registered occupancy only; a dead entry drains without id_ready.
module fetch_buffer #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 226
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [1:0]               if_valid,
  input  logic [2*ENTRY_W-1:0]     if_entry,
  input  logic [1:0]               flush,
  input  logic [1:0]               id_ready,
  output logic [1:0]               stall,
  output logic [1:0]               out_valid,
  output logic [2*ENTRY_W-1:0]     out_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage: payload has no reset; the live bits and pointers decide what is meaningful.
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   live_q, live_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic [CW-1:0]      free;
  logic [1:0]         acc;      // input slot k is written this cycle
  logic [1:0]         occ;      // output slot k holds an entry (live or dead)
  logic [1:0]         eff;      // output slot k is live and not being squashed now
  logic [1:0]         deq;      // output slot k retires this cycle
  logic [1:0]         n_enq;
  logic [1:0]         n_deq;
  logic [ENTRY_W-1:0] in_e  [2];
  logic [ENTRY_W-1:0] rd_e  [2];
  logic [PW-1:0]      rd_idx[2];
  logic [PW-1:0]      wr_idx[2];
  logic [1:0]         in_tid;
  logic [1:0]         rd_tid;

  // Per-slot decode of the input and output windows, stall and dequeue decisions.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    stall[0]  = free < CW'(1);
    stall[1]  = free < CW'(2);
    out_entry = '0;
    for (int k = 0; k < 2; k++) begin
      in_e[k]   = if_entry[k*ENTRY_W +: ENTRY_W];
      in_tid[k] = in_e[k][ENTRY_W-1];
      // A slot written while its stall bit is set would overflow, so it is dropped.
      acc[k]    = if_valid[k] && !flush[in_tid[k]] && !stall[k];
      rd_idx[k] = head_q + PW'(k);
      rd_e[k]   = mem_q[rd_idx[k]];
      rd_tid[k] = rd_e[k][ENTRY_W-1];
      occ[k]    = count_q > CW'(k);
      eff[k]    = occ[k] && live_q[rd_idx[k]] && !flush[rd_tid[k]];
      out_valid[k] = eff[k];
      if (occ[k]) out_entry[k*ENTRY_W +: ENTRY_W] = rd_e[k];
    end
    // Holes in the input are compacted: slot1 lands right after slot0 only if slot0 was taken.
    wr_idx[0] = tail_q;
    wr_idx[1] = tail_q + PW'(acc[0]);
    // Dead (or being-squashed) entries retire without waiting for decode.
    deq[0] = occ[0] && (!eff[0] || id_ready[0]);
    deq[1] = deq[0] && occ[1] && (!eff[1] || id_ready[1]);
    n_enq  = {1'b0, acc[0]} + {1'b0, acc[1]};
    n_deq  = {1'b0, deq[0]} + {1'b0, deq[1]};
  end

  // Next-state for pointers, occupancy and live bits, including squash.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[mem_q[i][ENTRY_W-1]]) live_d[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) live_d[wr_idx[k]] = 1'b1;
    end
    head_d  = head_q + PW'(n_deq);
    tail_d  = tail_q + PW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(n_deq);
    // Squashing both threads kills everything, so skip the drain entirely.
    if (&flush) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
      live_d  = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // Payload write at the compacted tail positions.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) mem_q[wr_idx[k]] <= in_e[k];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios followed by random traffic, with a
// queue-based reference model for occupancy and a scoreboard for decode order.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int EW    = 226;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [1:0]        if_valid;
  logic [2*EW-1:0]   if_entry;
  logic [1:0]        flush;
  logic [1:0]        id_ready;
  logic [1:0]        stall;
  logic [1:0]        out_valid;
  logic [2*EW-1:0]   out_entry;
  logic [3:0]        count;

  fetch_buffer #(.DEPTH(DEPTH), .ENTRY_W(EW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .if_valid (if_valid),
    .if_entry (if_entry),
    .flush    (flush),
    .id_ready (id_ready),
    .stall    (stall),
    .out_valid(out_valid),
    .out_entry(out_entry),
    .count    (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [EW-1:0] e;
    bit            live;
  } ment_t;

  ment_t         occ_m[$];   // every occupied entry, oldest first
  logic [EW-1:0] exp_q[$];   // entries decode is still owed, in order
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit tid, input logic [63:0] pc);
    logic [EW-1:0] e;
    e = {tid, 1'($urandom), {$urandom, $urandom}, pc + 64'd4, pc, $urandom};
    return e;
  endfunction

  // Monitor/model state (module scope so nothing is re-initialised per evaluation).
  int            sz;
  int            fr;
  bit            m_eff[2];
  bit            rt0, rt1;
  logic [EW-1:0] m_ent[2];
  logic [1:0]    m_vld;
  logic [1:0]    m_stall;
  logic [EW-1:0] in_k;
  logic [EW-1:0] popped;

  // Compare the DUT against the model mid-cycle, then advance the model across the next edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      occ_m.delete();
      exp_q.delete();
    end else begin
      sz = occ_m.size();
      // Squashed entries are no longer owed to decode.
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (flush[exp_q[i][EW-1]]) exp_q.delete(i);
      end
      for (int k = 0; k < 2; k++) begin
        m_eff[k] = (sz > k) && occ_m[k].live && !flush[occ_m[k].e[EW-1]];
        m_ent[k] = (sz > k) ? occ_m[k].e : '0;
        m_vld[k] = m_eff[k];
      end
      m_stall = {(DEPTH - sz) < 2, (DEPTH - sz) < 1};
      chk("count", EW'(count), EW'(sz));
      chk("stall", EW'(stall), EW'(m_stall));
      chk("out_valid", EW'(out_valid), EW'(m_vld));
      chk("out_entry0", out_entry[EW-1:0], m_ent[0]);
      chk("out_entry1", out_entry[2*EW-1:EW], m_ent[1]);

      // Scoreboard: whatever decode actually takes must be the next owed entry.
      if (out_valid[0] && id_ready[0]) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_slot0: got %h expected no delivery", out_entry[EW-1:0]);
        end else begin
          popped = exp_q.pop_front();
          chk("sb_slot0", out_entry[EW-1:0], popped);
        end
      end
      if (out_valid[1] && id_ready[1] && id_ready[0]) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_slot1: got %h expected no delivery", out_entry[2*EW-1:EW]);
        end else begin
          popped = exp_q.pop_front();
          chk("sb_slot1", out_entry[2*EW-1:EW], popped);
        end
      end

      // Advance the reference model.
      fr = DEPTH - sz;
      if (flush == 2'b11) begin
        occ_m.delete();
      end else begin
        rt0 = (sz > 0) && (!m_eff[0] || id_ready[0]);
        rt1 = rt0 && (sz > 1) && (!m_eff[1] || id_ready[1]);
        if (rt0) void'(occ_m.pop_front());
        if (rt1) void'(occ_m.pop_front());
        foreach (occ_m[i]) if (flush[occ_m[i].e[EW-1]]) occ_m[i].live = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        in_k = if_entry[k*EW +: EW];
        if (if_valid[k] && !flush[in_k[EW-1]] && fr >= k + 1) begin
          occ_m.push_back('{e: in_k, live: 1'b1});
          exp_q.push_back(in_k);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [63:0] pc;
  logic [1:0]  r;

  initial begin
    reset_n  = 1'b0;
    if_valid = '0;
    if_entry = '0;
    flush    = '0;
    id_ready = '0;
    #2;
    chk("rst_count", EW'(count), '0);
    chk("rst_stall", EW'(stall), '0);
    chk("rst_out_valid", EW'(out_valid), '0);
    chk("rst_out_entry0", out_entry[EW-1:0], '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Fill: 2 per cycle for 4 cycles with decode stalled.
    pc = 64'h0;
    for (int c = 0; c < 4; c++) begin
      if_valid = 2'b11;
      if_entry = {mk(1'b0, pc + 64'd4), mk(1'b0, pc)};
      pc += 64'd8;
      tick();
    end
    if_entry = {mk(1'b0, 64'h104), mk(1'b0, 64'h100)};
    chk("fill_count", EW'(count), EW'(8));
    chk("fill_stall", EW'(stall), EW'(2'b11));
    tick();
    chk("full_hold_count", EW'(count), EW'(8));
    if_valid = 2'b00;

    // Drain the full queue at 2 per cycle.
    chk("drain_head_pc", EW'(out_entry[95:32]), EW'(64'h0));
    id_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("drain_count", EW'(count), EW'(6 - 2 * c));
    end

    // Slot1-only write into an empty queue.
    id_ready = 2'b00;
    if_valid = 2'b10;
    if_entry = {mk(1'b0, 64'h40), mk(1'b0, 64'h999)};
    tick();
    if_valid = 2'b00;
    chk("slot1_only_valid", EW'(out_valid), EW'(2'b01));
    chk("slot1_only_pc", EW'(out_entry[95:32]), EW'(64'h40));
    id_ready = 2'b11;
    tick();

    // Interleaved threads, squash thread 0.
    id_ready = 2'b00;
    if_valid = 2'b11;
    if_entry = {mk(1'b1, 64'h204), mk(1'b0, 64'h200)};
    tick();
    if_entry = {mk(1'b1, 64'h20C), mk(1'b0, 64'h208)};
    tick();
    if_valid = 2'b00;
    flush    = 2'b01;
    id_ready = 2'b11;
    tick();
    flush = 2'b00;
    tick();
    chk("squash_t0_count", EW'(count), '0);

    // Thread-1 squash while both slots arrive: only the thread-0 entry lands.
    id_ready = 2'b00;
    flush    = 2'b10;
    if_valid = 2'b11;
    if_entry = {mk(1'b0, 64'h304), mk(1'b1, 64'h300)};
    tick();
    flush    = 2'b00;
    if_valid = 2'b00;
    chk("arrive_squash_count", EW'(count), EW'(1));
    chk("arrive_squash_pc", EW'(out_entry[95:32]), EW'(64'h304));
    id_ready = 2'b11;
    tick();

    // Asynchronous reset with 5 entries queued.
    id_ready = 2'b00;
    if_valid = 2'b11;
    if_entry = {mk(1'b0, 64'h404), mk(1'b1, 64'h400)};
    tick();
    if_entry = {mk(1'b1, 64'h40C), mk(1'b0, 64'h408)};
    tick();
    if_valid = 2'b01;
    if_entry = {mk(1'b0, 64'h414), mk(1'b0, 64'h410)};
    tick();
    if_valid = 2'b00;
    chk("pre_reset_count", EW'(count), EW'(5));
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_count", EW'(count), '0);
    chk("async_rst_valid", EW'(out_valid), '0);
    chk("async_rst_stall", EW'(stall), '0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Random traffic, including stalled writes and occasional squashes.
    pc = 64'h1000;
    for (int c = 0; c < 3000; c++) begin
      if_valid = 2'($urandom);
      if_entry = {mk(1'($urandom), pc + 64'd4), mk(1'($urandom), pc)};
      pc += 64'd8;
      flush = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      r = 2'($urandom_range(0, 2));
      id_ready = (r == 2'd0) ? 2'b00 : (r == 2'd1) ? 2'b01 : 2'b11;
      tick();
    end

    if_valid = 2'b00;
    flush    = 2'b00;
    id_ready = 2'b11;
    repeat (8) tick();
    chk("final_count", EW'(count), '0);
    chk("final_owed", EW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
